// File: rtl/sram_port_arbiter.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | sram_port_arbiter: two-port arbiter and strobe sequencer for async SRAM. |
// | Define SRAM_ARB_FIXED_PRIO_EN for fixed priority (port 0 wins ties).     |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
module sram_port_arbiter #(
    parameter int ADDR_WIDTH = 16,
    parameter int DATA_WIDTH = 16,
    parameter int RD_WAIT    = 1,
    parameter int WR_PULSE   = 1
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  req0,
    input  logic                  req1,
    input  logic                  we0,
    input  logic                  we1,
    input  logic [ADDR_WIDTH-1:0] addr0,
    input  logic [ADDR_WIDTH-1:0] addr1,
    input  logic [DATA_WIDTH-1:0] wdata0,
    input  logic [DATA_WIDTH-1:0] wdata1,
    output logic                  ack0,
    output logic                  ack1,
    output logic [DATA_WIDTH-1:0] rdata,
    output logic [ADDR_WIDTH-1:0] sram_addr,
    inout  wire  [DATA_WIDTH-1:0] sram_data,
    output logic                  notCS,
    output logic                  notOE,
    output logic                  notWE
);

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_RD       = 3'd1,
        ST_WR_SETUP = 3'd2,
        ST_WR_PULSE = 3'd3,
        ST_WR_HOLD  = 3'd4,
        ST_DONE     = 3'd5
    } state_e;

    localparam int CNT_MAX = (RD_WAIT > WR_PULSE) ? RD_WAIT : WR_PULSE;
    localparam int CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;

    state_e                state_q, state_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic                  port_q, port_d;
    logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
    logic [ADDR_WIDTH-1:0] sram_addr_q, sram_addr_d;
    logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
    logic                  ncs_q, ncs_d;
    logic                  noe_q, noe_d;
    logic                  nwe_q, nwe_d;
    logic                  drive_q, drive_d;
    logic                  ack0_q, ack0_d;
    logic                  ack1_q, ack1_d;
    logic                  grant_v;
    logic                  grant_port;
`ifndef SRAM_ARB_FIXED_PRIO_EN
    logic                  last_grant_q, last_grant_d;
`endif

    // Tie-break between simultaneous requests; a lone requester always wins.
    always_comb begin
        grant_v = req0 | req1;
        if (req0 && req1) begin
`ifdef SRAM_ARB_FIXED_PRIO_EN
            grant_port = 1'b0;
`else
            grant_port = ~last_grant_q;
`endif
        end else begin
            grant_port = req1 & ~req0;
        end
    end

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        port_d      = port_q;
        wdata_d     = wdata_q;
        sram_addr_d = sram_addr_q;
        rdata_d     = rdata_q;
`ifndef SRAM_ARB_FIXED_PRIO_EN
        last_grant_d = last_grant_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (grant_v) begin
                    port_d      = grant_port;
                    sram_addr_d = grant_port ? addr1 : addr0;
                    wdata_d     = grant_port ? wdata1 : wdata0;
`ifndef SRAM_ARB_FIXED_PRIO_EN
                    last_grant_d = grant_port;
`endif
                    if (grant_port ? we1 : we0) begin
                        state_d = ST_WR_SETUP;
                    end else begin
                        state_d = ST_RD;
                        cnt_d   = CNT_W'(RD_WAIT - 1);
                    end
                end
            end
            ST_RD: begin
                if (cnt_q == '0) begin
                    rdata_d = sram_data;
                    state_d = ST_DONE;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            ST_WR_SETUP: begin
                state_d = ST_WR_PULSE;
                cnt_d   = CNT_W'(WR_PULSE - 1);
            end
            ST_WR_PULSE: begin
                if (cnt_q == '0) begin
                    state_d = ST_WR_HOLD;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            ST_WR_HOLD: state_d = ST_WR_HOLD == state_q ? ST_DONE : ST_IDLE;
            ST_DONE:    state_d = ST_IDLE;
            default:    state_d = ST_IDLE;
        endcase

        // Strobes are decoded from the next state so the pins come straight off flops.
        ncs_d   = (state_d == ST_IDLE) || (state_d == ST_DONE);
        noe_d   = (state_d != ST_RD);
        nwe_d   = (state_d != ST_WR_PULSE);
        drive_d = (state_d == ST_WR_SETUP) || (state_d == ST_WR_PULSE) ||
                  (state_d == ST_WR_HOLD);
        ack0_d  = (state_d == ST_DONE) && !port_d;
        ack1_d  = (state_d == ST_DONE) && port_d;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            port_q      <= 1'b0;
            wdata_q     <= '0;
            sram_addr_q <= '0;
            rdata_q     <= '0;
            ncs_q       <= 1'b1;
            noe_q       <= 1'b1;
            nwe_q       <= 1'b1;
            drive_q     <= 1'b0;
            ack0_q      <= 1'b0;
            ack1_q      <= 1'b0;
`ifndef SRAM_ARB_FIXED_PRIO_EN
            last_grant_q <= 1'b1;
`endif
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            port_q      <= port_d;
            wdata_q     <= wdata_d;
            sram_addr_q <= sram_addr_d;
            rdata_q     <= rdata_d;
            ncs_q       <= ncs_d;
            noe_q       <= noe_d;
            nwe_q       <= nwe_d;
            drive_q     <= drive_d;
            ack0_q      <= ack0_d;
            ack1_q      <= ack1_d;
`ifndef SRAM_ARB_FIXED_PRIO_EN
            last_grant_q <= last_grant_d;
`endif
        end
    end

    assign sram_data = drive_q ? wdata_q : {DATA_WIDTH{1'bz}};
    assign sram_addr = sram_addr_q;
    assign rdata     = rdata_q;
    assign notCS     = ncs_q;
    assign notOE     = noe_q;
    assign notWE     = nwe_q;
    assign ack0      = ack0_q;
    assign ack1      = ack1_q;

endmodule
`default_nettype wire

// File: tb/tb_sram_port_arbiter.sv
`default_nettype none
// tb_sram_port_arbiter: directed scoreboard bench with SRAM models for two parameter sets.
module tb_sram_port_arbiter;

    typedef struct {
        logic        port;
        logic        rd;
        logic [15:0] data;
    } exp_t;

    logic clock = 1'b0;
    always #5 clock = ~clock;

    logic        reset_v [2];
    logic        req0_v  [2];
    logic        req1_v  [2];
    logic        we0_v   [2];
    logic        we1_v   [2];
    logic [15:0] addr0_v [2];
    logic [15:0] addr1_v [2];
    logic [15:0] wdata0_v[2];
    logic [15:0] wdata1_v[2];

    logic        ack0_a, ack1_a, cs_a, oe_a, we_a;
    logic        ack0_b, ack1_b, cs_b, oe_b, we_b;
    logic [15:0] rdata_a, saddr_a, rdata_b, saddr_b;
    wire  [15:0] bus_a, bus_b;

    logic [15:0] mem_a [256];
    logic [15:0] mem_b [256];

    int   tests = 0;
    int   fails = 0;
    int   wlow   [2];
    logic pwe    [2];
    logic pact   [2];
    logic [15:0] haddr [2];
    int   ackcnt [2];
    exp_t sbq [2][$];

    sram_port_arbiter #(.ADDR_WIDTH(16), .DATA_WIDTH(16), .RD_WAIT(1), .WR_PULSE(1)) u_dut_a (
        .clock(clock), .reset(reset_v[0]),
        .req0(req0_v[0]), .req1(req1_v[0]), .we0(we0_v[0]), .we1(we1_v[0]),
        .addr0(addr0_v[0]), .addr1(addr1_v[0]), .wdata0(wdata0_v[0]), .wdata1(wdata1_v[0]),
        .ack0(ack0_a), .ack1(ack1_a), .rdata(rdata_a), .sram_addr(saddr_a),
        .sram_data(bus_a), .notCS(cs_a), .notOE(oe_a), .notWE(we_a)
    );

    sram_port_arbiter #(.ADDR_WIDTH(16), .DATA_WIDTH(16), .RD_WAIT(3), .WR_PULSE(2)) u_dut_b (
        .clock(clock), .reset(reset_v[1]),
        .req0(req0_v[1]), .req1(req1_v[1]), .we0(we0_v[1]), .we1(we1_v[1]),
        .addr0(addr0_v[1]), .addr1(addr1_v[1]), .wdata0(wdata0_v[1]), .wdata1(wdata1_v[1]),
        .ack0(ack0_b), .ack1(ack1_b), .rdata(rdata_b), .sram_addr(saddr_b),
        .sram_data(bus_b), .notCS(cs_b), .notOE(oe_b), .notWE(we_b)
    );

    // Asynchronous SRAM models: read data while selected and output-enabled, commit on notWE rise.
    assign bus_a = (!cs_a && !oe_a) ? mem_a[saddr_a[7:0]] : 16'hzzzz;
    assign bus_b = (!cs_b && !oe_b) ? mem_b[saddr_b[7:0]] : 16'hzzzz;
    always @(posedge we_a) if (!cs_a) mem_a[saddr_a[7:0]] <= bus_a;
    always @(posedge we_b) if (!cs_b) mem_b[saddr_b[7:0]] <= bus_b;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        tests++;
        assert (obs === expv) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    task automatic mon(input int i, input logic cs, input logic oe, input logic we,
                       input logic a0, input logic a1, input logic rst,
                       input logic [15:0] sa, input logic [15:0] rd, input int wp);
        logic act;
        exp_t e;
        chk("oe_we_overlap", 32'(oe | we), 32'd1);
        chk("ack_exclusive", 32'(a0 & a1), 32'd0);
        act = !cs || a0 || a1;
        if (act && pact[i]) chk("addr_stable", 32'(sa), 32'(haddr[i]));
        else if (act) haddr[i] = sa;
        pact[i] = act;
        if (!we) begin
            if (pwe[i]) begin
                chk("we_fall_cs", 32'(cs), 32'd0);
                wlow[i] = 1;
            end else begin
                wlow[i]++;
            end
        end else if (!pwe[i] && !rst) begin
            chk("we_pulse_len", 32'(wlow[i]), 32'(wp));
            chk("we_rise_cs", 32'(cs), 32'd0);
        end
        pwe[i] = we;
        if (a0 || a1) begin
            ackcnt[i]++;
            chk("ack_expected", 32'(sbq[i].size() > 0), 32'd1);
            if (sbq[i].size() > 0) begin
                e = sbq[i].pop_front();
                chk("ack_port", 32'(a1), 32'(e.port));
                if (e.rd) chk("rdata", 32'(rd), 32'(e.data));
            end
        end
    endtask

    always @(posedge clock) begin
        #1;
        mon(0, cs_a, oe_a, we_a, ack0_a, ack1_a, reset_v[0], saddr_a, rdata_a, 1);
        mon(1, cs_b, oe_b, we_b, ack0_b, ack1_b, reset_v[1], saddr_b, rdata_b, 2);
    end

    task automatic do_txn(input int i, input logic p, input logic w,
                          input logic [15:0] a, input logic [15:0] d, input int lat);
        exp_t e;
        int   n;
        logic got;
        @(negedge clock);
        e.port = p;
        e.rd   = !w;
        e.data = d;
        sbq[i].push_back(e);
        if (!p) begin
            req0_v[i] = 1'b1; we0_v[i] = w; addr0_v[i] = a; wdata0_v[i] = d;
        end else begin
            req1_v[i] = 1'b1; we1_v[i] = w; addr1_v[i] = a; wdata1_v[i] = d;
        end
        n   = 0;
        got = 1'b0;
        while (!got && n < 40) begin
            @(negedge clock);
            n++;
            if (i == 0) got = p ? ack1_a : ack0_a;
            else        got = p ? ack1_b : ack0_b;
        end
        chk(w ? "wr_latency" : "rd_latency", 32'(n), 32'(lat));
        if (!p) req0_v[i] = 1'b0;
        else    req1_v[i] = 1'b0;
    endtask

    initial begin : stim
        int base;
        int n;
        exp_t e;
        for (int k = 0; k < 256; k++) begin
            mem_a[k] = 16'h0000;
            mem_b[k] = 16'h0000;
        end
        for (int k = 0; k < 2; k++) begin
            reset_v[k] = 1'b1; req0_v[k] = 1'b0; req1_v[k] = 1'b0;
            we0_v[k] = 1'b0; we1_v[k] = 1'b0;
            addr0_v[k] = '0; addr1_v[k] = '0; wdata0_v[k] = '0; wdata1_v[k] = '0;
            wlow[k] = 0; pwe[k] = 1'b1; pact[k] = 1'b0; haddr[k] = '0; ackcnt[k] = 0;
        end
        repeat (3) @(negedge clock);
        chk("rst_strobes_a", 32'({cs_a, oe_a, we_a, ack0_a, ack1_a}), 32'b11100);
        chk("rst_rdata_a", 32'(rdata_a), 32'd0);
        chk("rst_addr_a", 32'(saddr_a), 32'd0);
        chk("rst_strobes_b", 32'({cs_b, oe_b, we_b, ack0_b, ack1_b}), 32'b11100);
        reset_v[0] = 1'b0;
        reset_v[1] = 1'b0;

        // Basic write then read-back through the other port.
        do_txn(0, 1'b0, 1'b1, 16'h0010, 16'hBEEF, 4);
        chk("mem_0010", 32'(mem_a[8'h10]), 32'hBEEF);
        do_txn(0, 1'b1, 1'b0, 16'h0010, 16'hBEEF, 2);
        chk("rdata_after_rd", 32'(rdata_a), 32'hBEEF);
        do_txn(0, 1'b1, 1'b1, 16'h0020, 16'h1234, 4);
        chk("rdata_held", 32'(rdata_a), 32'hBEEF);

        // Both ports held for four transactions.
        @(negedge clock);
        for (int k = 0; k < 4; k++) begin
`ifdef SRAM_ARB_FIXED_PRIO_EN
            e.port = 1'b0;
`else
            e.port = 1'(k % 2);
`endif
            e.rd   = 1'b0;
            e.data = 16'h0000;
            sbq[0].push_back(e);
        end
        we0_v[0] = 1'b1; addr0_v[0] = 16'h0001; wdata0_v[0] = 16'h1111;
        we1_v[0] = 1'b1; addr1_v[0] = 16'h0002; wdata1_v[0] = 16'h2222;
        req0_v[0] = 1'b1; req1_v[0] = 1'b1;
        base = ackcnt[0];
        n = 0;
        while (ackcnt[0] - base < 4 && n < 100) begin
            @(negedge clock);
            n++;
        end
        req0_v[0] = 1'b0; req1_v[0] = 1'b0;
        chk("held_acks", 32'(ackcnt[0] - base), 32'd4);
        do_txn(0, 1'b1, 1'b0, 16'h0001, 16'h1111, 2);
`ifdef SRAM_ARB_FIXED_PRIO_EN
        do_txn(0, 1'b0, 1'b0, 16'h0002, 16'h0000, 2);
`else
        do_txn(0, 1'b0, 1'b0, 16'h0002, 16'h2222, 2);
`endif

        // Reset during the write pulse aborts without ack.
        @(negedge clock);
        req0_v[0] = 1'b1; we0_v[0] = 1'b1; addr0_v[0] = 16'h0030; wdata0_v[0] = 16'h5555;
        n = 0;
        while (we_a !== 1'b0 && n < 20) begin
            @(negedge clock);
            n++;
        end
        chk("reached_wr_pulse", 32'(we_a), 32'd0);
        reset_v[0] = 1'b1;
        req0_v[0]  = 1'b0;
        @(negedge clock);
        chk("abort_strobes", 32'({cs_a, oe_a, we_a, ack0_a, ack1_a}), 32'b11100);
        reset_v[0] = 1'b0;
        repeat (3) @(negedge clock);
        do_txn(0, 1'b0, 1'b0, 16'h0010, 16'hBEEF, 2);

        // Stretched timing instance.
        do_txn(1, 1'b1, 1'b1, 16'h0040, 16'hA5A5, 5);
        chk("mem_b_0040", 32'(mem_b[8'h40]), 32'hA5A5);
        do_txn(1, 1'b0, 1'b0, 16'h0040, 16'hA5A5, 4);

        repeat (3) @(negedge clock);
        chk("sb_drained", 32'(sbq[0].size() + sbq[1].size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "timeout");
    end

endmodule
`default_nettype wire
